scene_fade_mux: RTL and testbench
=================================

SCENE_FADE_MUX -- requirements
Module: scene_fade_mux

Interface
REQ-001 SHALL have parameter NUM_SCENES, default 4: number of scene sources, scene codes 1..NUM_SCENES.
REQ-002 SHALL have parameter RGB_W, default 12: packed RGB width, three equal channels of RGB_W/3 bits.
REQ-003 SHALL have parameter ADDR_W, default 17: pixel memory address width.
REQ-004 SHALL have parameter FADE_STEPS, default 16: power of two, number of brightness levels.
REQ-005 SHALL have parameter FRAMES_PER_STEP, default 2: frame_tick pulses per brightness step, at least 1.
REQ-006 SHALL have parameter FADE_EN, default 1: 0 selects instant switching with no fade.
REQ-007 SHALL have parameter RESET_SCENE, default 1: active scene code after reset.
REQ-008 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-009 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-010 SHALL have port frame_tick, input, 1 bit: one-cycle pulse at each frame start.
REQ-011 SHALL have port valid, input, 1 bit: VGA active-video qualifier.
REQ-012 SHALL have port scene_req, input, 4 bits: requested scene code.
REQ-013 SHALL have port scene_rgb_flat, input, NUM_SCENES*RGB_W bits: scene k (code k+1) RGB at slice k.
REQ-014 SHALL have port scene_addr_flat, input, NUM_SCENES*ADDR_W bits: scene k pixel address at slice k.
REQ-015 SHALL have port rgb_out, output, RGB_W bits: faded, registered pixel.
REQ-016 SHALL have port addr_out, output, ADDR_W bits: pixel address of the active scene.
REQ-017 SHALL have port active_scene, output, 4 bits: scene code currently displayed.
REQ-018 SHALL have port busy, output, 1 bit: high while any transition is in progress.

Function
REQ-019 SHALL define brightness level L in 0..FADE_STEPS; each channel out = (ch*L) >> log2(FADE_STEPS), truncated, so L=FADE_STEPS passes the pixel unchanged.
REQ-020 SHALL register rgb_out: it reflects valid, active_scene, L and source RGB from the previous cycle (1-cycle latency); valid=0 gives 0.
REQ-021 SHALL drive addr_out combinationally from active_scene; an invalid active code (0 or >NUM_SCENES) gives addr 0 and black RGB.
REQ-022 SHALL implement FSM states IDLE, FADE_OUT, SWAP, FADE_IN.
REQ-023 In IDLE (L=FADE_STEPS), when scene_req != active_scene, SHALL go to FADE_OUT and latch target=scene_req.
REQ-024 SHALL count a step every FRAMES_PER_STEP frame_ticks, with the frame counter cleared on each state entry.
REQ-025 In FADE_OUT, each step SHALL decrement L; at L=0 the FSM SHALL enter SWAP.
REQ-026 SWAP SHALL last one cycle, setting active_scene=target, then enter FADE_IN.
REQ-027 In FADE_IN, each step SHALL increment L; at L=FADE_STEPS the FSM SHALL return to IDLE.
REQ-028 In FADE_OUT, target SHALL follow scene_req every cycle (latest request wins).
REQ-029 In FADE_OUT, if scene_req==active_scene, SHALL enter FADE_IN from the current L (reversal).
REQ-030 In FADE_IN, if scene_req!=active_scene, SHALL enter FADE_OUT from the current L and latch the new target.
REQ-031 busy SHALL be 1 in every state except IDLE.
REQ-032 With FADE_EN=0, active_scene SHALL follow scene_req one cycle later, L stays FADE_STEPS, and busy stays 0.

Reset
REQ-033 On rst SHALL set state=IDLE, L=FADE_STEPS, active_scene=RESET_SCENE, target=RESET_SCENE, frame counter=0, rgb_out=0, busy=0; reset asserted mid-fade aborts the fade immediately.

Structure
REQ-034 The shared package scene_pkg SHALL hold scene codes START=1, CHOOSE=2, FIGHT=3, WIN=4 and the FSM state encoding.
REQ-035 The per-channel multiply-shift SHALL be one sub-module, rgb_scaler, instantiated once.

Verification
REQ-036 Reset, scene_req=1, scene 1 rgb=12'hFFF, valid=1 -> rgb_out=12'hFFF one cycle later, busy=0.
REQ-037 scene_req 1->3 -> busy next cycle; L=8 after 16 ticks gives rgb_out=12'h777; SWAP after 32 ticks; IDLE with active_scene=3 after 32 more ticks.
REQ-038 Request 3 during FADE_OUT at L=10, then 1 -> FADE_IN from L=10, active_scene remains 1, idle after 12 ticks.
REQ-039 scene_req=2 then 4 during FADE_OUT -> SWAP sets active_scene=4.
REQ-040 scene_req=0 -> after fade, addr_out=0 and rgb_out=0; valid=0 at any time -> rgb_out=0 next cycle.
REQ-041 rst asserted at L=5 in FADE_IN -> next cycle IDLE, L=16, active_scene=1, rgb_out=0; FADE_EN=0 switch completes in 1 cycle.

Source files
------------

// File: rtl/scene_pkg.sv
// Shared definitions for the scene fade multiplexer.
// Holds the scene codes used by the game front-end and the encoding
// of the fade state machine.
package scene_pkg;

  localparam int SCENE_W = 4;

  // Scene codes; 0 is never a valid scene.
  localparam logic [SCENE_W-1:0] START  = 4'd1;
  localparam logic [SCENE_W-1:0] CHOOSE = 4'd2;
  localparam logic [SCENE_W-1:0] FIGHT  = 4'd3;
  localparam logic [SCENE_W-1:0] WIN    = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_SWAP     = 2'd2,
    ST_FADE_IN  = 2'd3
  } fade_state_e;

endpackage

// File: rtl/rgb_scaler.sv
// Brightness scaler: multiplies each RGB channel by a level in
// 0..FADE_STEPS and drops log2(FADE_STEPS) fraction bits (truncation).
// Level FADE_STEPS returns the pixel unchanged, level 0 returns black.
// Ports:
//   rgb_i   - packed RGB pixel, three channels of RGB_W/3 bits
//   level_i - brightness level
//   rgb_o   - scaled pixel (combinational)
module rgb_scaler
  import scene_pkg::*;
#(
  parameter int RGB_W      = 12,
  parameter int FADE_STEPS = 16,
  parameter int LVL_W      = $clog2(FADE_STEPS) + 1
) (
  input  logic [RGB_W-1:0] rgb_i,
  input  logic [LVL_W-1:0] level_i,
  output logic [RGB_W-1:0] rgb_o
);

  localparam int CH_W   = RGB_W / 3;
  localparam int SHIFT  = $clog2(FADE_STEPS);
  localparam int PROD_W = CH_W + LVL_W;

  function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0]  ch,
                                               input logic [LVL_W-1:0] lvl);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(ch) * PROD_W'(lvl);
    // ch*lvl >> SHIFT never exceeds ch, so the cast loses nothing.
    return CH_W'(prod >> SHIFT);
  endfunction

  always_comb begin
    rgb_o = '0;
    for (int c = 0; c < 3; c++) begin
      rgb_o[c*CH_W +: CH_W] = scale_ch(rgb_i[c*CH_W +: CH_W], level_i);
    end
  end

endmodule

// File: rtl/scene_fade_mux.sv
// Scene multiplexer with fade-to-black transitions.
// Selects one of NUM_SCENES pixel sources; on a scene change the picture
// fades out frame by frame, the source is swapped at black, then fades in.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   frame_tick      - one-cycle pulse per frame start, paces the fade
//   valid           - active-video qualifier, blanks rgb_out when low
//   scene_req       - requested scene code (1..NUM_SCENES)
//   scene_rgb_flat  - per-scene RGB, scene code k+1 at slice k
//   scene_addr_flat - per-scene pixel address, scene code k+1 at slice k
//   rgb_out         - faded pixel, registered (1-cycle latency)
//   addr_out        - pixel address of the active scene (combinational)
//   active_scene    - scene code currently displayed
//   busy            - high while a transition is in progress
module scene_fade_mux
  import scene_pkg::*;
#(
  parameter int NUM_SCENES      = 4,
  parameter int RGB_W           = 12,
  parameter int ADDR_W          = 17,
  parameter int FADE_STEPS      = 16,
  parameter int FRAMES_PER_STEP = 2,
  parameter int FADE_EN         = 1,
  parameter int RESET_SCENE     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_tick,
  input  logic                         valid,
  input  logic [SCENE_W-1:0]           scene_req,
  input  logic [NUM_SCENES*RGB_W-1:0]  scene_rgb_flat,
  input  logic [NUM_SCENES*ADDR_W-1:0] scene_addr_flat,
  output logic [RGB_W-1:0]             rgb_out,
  output logic [ADDR_W-1:0]            addr_out,
  output logic [SCENE_W-1:0]           active_scene,
  output logic                         busy
);

  localparam int LVL_W = $clog2(FADE_STEPS) + 1;
  localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [LVL_W-1:0]   LVL_MAX   = LVL_W'(FADE_STEPS);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [SCENE_W-1:0] SCENE_RST = SCENE_W'(RESET_SCENE);

  fade_state_e        state_q, state_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [SCENE_W-1:0] active_q, active_d;
  logic [SCENE_W-1:0] target_q, target_d;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d;
  logic [RGB_W-1:0]   rgb_p1_q;

  logic               step;
  logic [RGB_W-1:0]   src_rgb;
  logic [RGB_W-1:0]   scaled_rgb;

  assign step = frame_tick && (fcnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    active_d = active_q;
    target_d = target_q;
    fcnt_d   = fcnt_q;

    if (frame_tick) begin
      fcnt_d = step ? '0 : fcnt_q + 1'b1;
    end

    if (FADE_EN == 0) begin
      // Instant switching: no fade, no transition states.
      state_d  = ST_IDLE;
      level_d  = LVL_MAX;
      active_d = scene_req;
      target_d = scene_req;
      fcnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (scene_req != active_q) begin
            state_d  = ST_FADE_OUT;
            target_d = scene_req;
          end
        end
        ST_FADE_OUT: begin
          // Latest request wins; a request back to the shown scene
          // reverses the fade from wherever the level currently is.
          target_d = scene_req;
          if (scene_req == active_q) begin
            state_d = ST_FADE_IN;
          end else if (level_q == '0) begin
            state_d = ST_SWAP;
          end else if (step) begin
            level_d = level_q - 1'b1;
          end
        end
        ST_SWAP: begin
          active_d = target_q;
          state_d  = ST_FADE_IN;
        end
        ST_FADE_IN: begin
          if (scene_req != active_q) begin
            state_d  = ST_FADE_OUT;
            target_d = scene_req;
          end else if (level_q == LVL_MAX) begin
            state_d = ST_IDLE;
          end else if (step) begin
            level_d = level_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Every state starts counting frames from zero.
    if (state_d != state_q) begin
      fcnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      level_q  <= LVL_MAX;
      active_q <= SCENE_RST;
      target_q <= SCENE_RST;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      active_q <= active_d;
      target_q <= target_d;
      fcnt_q   <= fcnt_d;
    end
  end

  // Source select; codes outside 1..NUM_SCENES give address 0 and black.
  always_comb begin
    src_rgb  = '0;
    addr_out = '0;
    for (int k = 0; k < NUM_SCENES; k++) begin
      if (active_q == SCENE_W'(k + 1)) begin
        src_rgb  = scene_rgb_flat[k*RGB_W +: RGB_W];
        addr_out = scene_addr_flat[k*ADDR_W +: ADDR_W];
      end
    end
  end

  rgb_scaler #(
    .RGB_W      (RGB_W),
    .FADE_STEPS (FADE_STEPS),
    .LVL_W      (LVL_W)
  ) u_scaler (
    .rgb_i   (src_rgb),
    .level_i (level_q),
    .rgb_o   (scaled_rgb)
  );

  // ---- stage p0 -> p1: registered output pixel ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_p1_q <= '0;
    end else begin
      rgb_p1_q <= valid ? scaled_rgb : '0;
    end
  end

  assign rgb_out      = rgb_p1_q;
  assign active_scene = active_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_scene_fade_mux.sv
module tb_scene_fade_mux;

  localparam int NS  = 4;
  localparam int RW  = 12;
  localparam int AW  = 17;

  logic            clk = 1'b0;
  logic            rst;
  logic            frame_tick;
  logic            valid;
  logic [3:0]      scene_req;
  logic [NS*RW-1:0] scene_rgb_flat;
  logic [NS*AW-1:0] scene_addr_flat;

  logic [RW-1:0]   rgb_out, inst_rgb;
  logic [AW-1:0]   addr_out, inst_addr;
  logic [3:0]      active_scene, inst_active;
  logic            busy, inst_busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int         due;
    logic [11:0] rgb;
  } sb_t;
  sb_t sb[$];
  sb_t sb_e;

  logic [11:0] pal [NS] = '{12'hFFF, 12'hA5C, 12'h3C9, 12'h8F1};

  scene_fade_mux u_dut (
    .clk             (clk),
    .rst             (rst),
    .frame_tick      (frame_tick),
    .valid           (valid),
    .scene_req       (scene_req),
    .scene_rgb_flat  (scene_rgb_flat),
    .scene_addr_flat (scene_addr_flat),
    .rgb_out         (rgb_out),
    .addr_out        (addr_out),
    .active_scene    (active_scene),
    .busy            (busy)
  );

  scene_fade_mux #(.FADE_EN(0)) u_inst (
    .clk             (clk),
    .rst             (rst),
    .frame_tick      (frame_tick),
    .valid           (valid),
    .scene_req       (scene_req),
    .scene_rgb_flat  (scene_rgb_flat),
    .scene_addr_flat (scene_addr_flat),
    .rgb_out         (inst_rgb),
    .addr_out        (inst_addr),
    .active_scene    (inst_active),
    .busy            (inst_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int k);
    return AW'(32'h1000 + k * 32'h111);
  endfunction

  // Reference brightness: each 4-bit channel times L, divided by 16, truncated.
  function automatic logic [11:0] scale(input logic [11:0] p, input int l);
    logic [11:0] r;
    int ch;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      ch = int'(p[c*4 +: 4]);
      r[c*4 +: 4] = 4'((ch * l) / 16);
    end
    return r;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      step(3);
    end
  endtask

  // Expected pixel for the inputs/state of the current cycle, due next cycle.
  task automatic expect_rgb(input logic [11:0] v);
    sb.push_back('{due: cyc + 1, rgb: v});
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      sb_e = sb.pop_front();
      if (sb_e.due < cyc) chk("sb_late", cyc, sb_e.due);
      else                chk("rgb_out", rgb_out, sb_e.rgb);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    frame_tick = 1'b0;
    valid      = 1'b1;
    scene_req  = 4'd1;
    for (int k = 0; k < NS; k++) begin
      scene_rgb_flat[k*RW +: RW]  = pal[k];
      scene_addr_flat[k*AW +: AW] = addr_of(k);
    end
    step(3);

    // Reset state
    chk("rst_rgb", rgb_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_active", active_scene, 1);
    rst = 1'b0;
    chk("idle_addr", addr_out, addr_of(0));
    expect_rgb(12'hFFF);
    step(1);
    chk("idle_busy", busy, 0);

    // Fade 1 -> 3
    scene_req = 4'd3;
    step(1);
    chk("fade_busy", busy, 1);
    ticks(16);
    chk("mid_active", active_scene, 1);
    expect_rgb(12'h777);
    step(1);
    valid = 1'b0;
    expect_rgb(12'h000);
    step(1);
    valid = 1'b1;
    ticks(16);
    chk("swap_active", active_scene, 3);
    chk("swap_busy", busy, 1);
    expect_rgb(scale(pal[2], 0));
    ticks(32);
    chk("in_done_busy", busy, 0);
    chk("in_done_active", active_scene, 3);
    chk("in_done_addr", addr_out, addr_of(2));
    expect_rgb(pal[2]);
    step(1);

    // Reversal: fade out of 3 toward 1, back to 3 at L=10
    scene_req = 4'd1;
    step(1);
    chk("inst_active", inst_active, 1);
    chk("inst_busy", inst_busy, 0);
    ticks(12);
    chk("inst_rgb", inst_rgb, pal[0]);
    chk("inst_addr", inst_addr, addr_of(0));
    expect_rgb(scale(pal[2], 10));
    scene_req = 4'd3;
    step(1);
    chk("rev_busy", busy, 1);
    chk("rev_active", active_scene, 3);
    expect_rgb(scale(pal[2], 10));
    ticks(11);
    chk("rev_still_busy", busy, 1);
    ticks(1);
    chk("rev_idle", busy, 0);
    chk("rev_active_end", active_scene, 3);

    // Latest request wins: 2 then 4
    scene_req = 4'd2;
    step(1);
    ticks(4);
    scene_req = 4'd4;
    ticks(28);
    chk("retarget_active", active_scene, 4);
    chk("inst_busy_fade", inst_busy, 0);
    ticks(32);
    chk("retarget_idle", busy, 0);
    expect_rgb(pal[3]);
    step(1);

    // Invalid scene code 0
    scene_req = 4'd0;
    step(1);
    ticks(64);
    chk("inv_active", active_scene, 0);
    chk("inv_addr", addr_out, 0);
    chk("inv_busy", busy, 0);
    expect_rgb(12'h000);
    step(1);

    // Reset in the middle of FADE_IN at L=5
    scene_req = 4'd1;
    step(1);
    ticks(32);
    chk("fi_active", active_scene, 1);
    ticks(10);
    chk("fi_busy", busy, 1);
    expect_rgb(scale(pal[0], 5));
    step(1);
    rst = 1'b1;
    step(1);
    chk("midrst_rgb", rgb_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_active", active_scene, 1);
    rst = 1'b0;
    expect_rgb(12'hFFF);
    step(2);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
